param_register_file: RTL and testbench

- Parametrised next-generation register file for the MIPS datapath.
- Generalised in data width, depth and read-port count, with two write ports for dual-retire configurations.
- Adds optional write-to-read bypass, optional hardwired zero register, and synchronous clear of every entry.
- Sits between decode (read addresses) and writeback (write ports); read data feeds the ALU operand muxes.

---
 rtl/param_register_file.sv | 98 +++++++++
 tb/tb_param_register_file.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_register_file.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | param_register_file: multi-read, dual-write register file with optional   |
// | write-to-read bypass, hardwired zero register and synchronous clear.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module param_register_file #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 32,
  parameter int NUM_READ = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_READ*ADDR_W-1:0]   readAddr,
  output logic [NUM_READ*DATA_W-1:0]   readData,
  input  logic                         writeEnable0,
  input  logic [ADDR_W-1:0]            writeReg0,
  input  logic [DATA_W-1:0]            writeData0,
  input  logic                         writeEnable1,
  input  logic [ADDR_W-1:0]            writeReg1,
  input  logic [DATA_W-1:0]            writeData1
);

  logic [DEPTH-1:0][DATA_W-1:0] entry_w;

  // Each entry decodes its own write; addresses >= DEPTH match no entry and are dropped.
  for (genvar e = 0; e < DEPTH; e++) begin : g_entry
    localparam logic [ADDR_W-1:0] c_IDX = ADDR_W'(e);

    if ((ZERO_REG != 0) && (e == 0)) begin : g_zero
      assign entry_w[e] = '0;
    end else begin : g_reg
      logic [DATA_W-1:0] data_q;
      logic [DATA_W-1:0] data_d;

      always_comb begin
        data_d = data_q;
        if (writeEnable1 && (writeReg1 == c_IDX)) begin
          data_d = writeData1;
        end else if (writeEnable0 && (writeReg0 == c_IDX)) begin
          data_d = writeData0;
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          data_q <= '0;
        end else begin
          data_q <= data_d;
        end
      end

      assign entry_w[e] = data_q;
    end
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_read
    logic [ADDR_W-1:0] addr_w;
    logic [DATA_W-1:0] stored_w;
    logic [DATA_W-1:0] data_w;
    logic              hit_w;
    logic              byp_ok_w;

    assign addr_w = readAddr[k*ADDR_W +: ADDR_W];

    // Out-of-range addresses never hit, so they read 0 and are never bypassed.
    always_comb begin
      stored_w = '0;
      hit_w    = 1'b0;
      for (int e = 0; e < DEPTH; e++) begin
        if (addr_w == ADDR_W'(e)) begin
          stored_w = entry_w[e];
          hit_w    = 1'b1;
        end
      end
    end

    always_comb begin
      byp_ok_w = hit_w && !reset && (BYPASS != 0)
                 && !((ZERO_REG != 0) && (addr_w == '0));
      data_w = stored_w;
      if (byp_ok_w) begin
        if (writeEnable1 && (writeReg1 == addr_w)) begin
          data_w = writeData1;
        end else if (writeEnable0 && (writeReg0 == addr_w)) begin
          data_w = writeData0;
        end
      end
    end

    assign readData[k*DATA_W +: DATA_W] = data_w;
  end

endmodule
`default_nettype wire

// File: tb/tb_param_register_file.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_param_register_file: directed self-checking bench for param_register_file|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_param_register_file;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  ra;
  logic [63:0] rd_a, rd_b;
  logic        we0, we1;
  logic [4:0]  wr0, wr1;
  logic [31:0] wd0, wd1;

  logic [19:0] s_ra;
  logic [63:0] s_rd;
  logic        s_we0, s_we1;
  logic [4:0]  s_wr0, s_wr1;
  logic [15:0] s_wd0, s_wd1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  param_register_file #(.BYPASS(1)) u_dut_byp (
    .clk(clk), .reset(reset), .readAddr(ra), .readData(rd_a),
    .writeEnable0(we0), .writeReg0(wr0), .writeData0(wd0),
    .writeEnable1(we1), .writeReg1(wr1), .writeData1(wd1)
  );

  param_register_file #(.BYPASS(0)) u_dut_nobyp (
    .clk(clk), .reset(reset), .readAddr(ra), .readData(rd_b),
    .writeEnable0(we0), .writeReg0(wr0), .writeData0(wd0),
    .writeEnable1(we1), .writeReg1(wr1), .writeData1(wd1)
  );

  param_register_file #(
    .DATA_W(16), .ADDR_W(5), .DEPTH(8), .NUM_READ(4), .BYPASS(1), .ZERO_REG(0)
  ) u_dut_small (
    .clk(clk), .reset(reset), .readAddr(s_ra), .readData(s_rd),
    .writeEnable0(s_we0), .writeReg0(s_wr0), .writeData0(s_wd0),
    .writeEnable1(s_we1), .writeReg1(s_wr1), .writeData1(s_wd1)
  );

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0; s_we0 = 1'b0; s_we1 = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    for (int a = 0; a < 32; a += 2) begin
      ra = {5'(a + 1), 5'(a)}; #1;
      n_cmp++;
      if (rd_a !== 64'd0) begin
        n_err++; $display("FAIL reset_byp addr=%0d: got %h expected 0", a, rd_a);
      end
      n_cmp++;
      if (rd_b !== 64'd0) begin
        n_err++; $display("FAIL reset_nobyp addr=%0d: got %h expected 0", a, rd_b);
      end
    end
    for (int a = 0; a < 8; a += 4) begin
      s_ra = {5'(a + 3), 5'(a + 2), 5'(a + 1), 5'(a)}; #1;
      n_cmp++;
      if (s_rd !== 64'd0) begin
        n_err++; $display("FAIL reset_small addr=%0d: got %h expected 0", a, s_rd);
      end
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i < 32; i++) begin
      @(negedge clk); we0 = 1'b1; wr0 = 5'(i); wd0 = 32'hA000_0000 + 32'(i);
    end
    @(negedge clk); idle();
    ra = {5'd3, 5'd2}; #1;
    n_cmp++;
    if (rd_a !== {32'hA000_0003, 32'hA000_0002}) begin
      n_err++; $display("FAIL fill_2_3_byp: got %h expected a0000003a0000002", rd_a);
    end
    n_cmp++;
    if (rd_b !== {32'hA000_0003, 32'hA000_0002}) begin
      n_err++; $display("FAIL fill_2_3_nobyp: got %h expected a0000003a0000002", rd_b);
    end
    ra = {5'd1, 5'd31}; #1;
    n_cmp++;
    if (rd_a !== {32'hA000_0001, 32'hA000_001F}) begin
      n_err++; $display("FAIL fill_31_1_byp: got %h expected a0000001a000001f", rd_a);
    end
    n_cmp++;
    if (rd_b !== {32'hA000_0001, 32'hA000_001F}) begin
      n_err++; $display("FAIL fill_31_1_nobyp: got %h expected a0000001a000001f", rd_b);
    end
    @(negedge clk); we0 = 1'b1; wr0 = 5'd0; wd0 = 32'd5; ra = {5'd0, 5'd0}; #1;
    n_cmp++;
    if (rd_a !== 64'd0) begin
      n_err++; $display("FAIL zero_reg_bypass: got %h expected 0", rd_a);
    end
    @(negedge clk); idle(); #1;
    n_cmp++;
    if (rd_a !== 64'd0) begin
      n_err++; $display("FAIL zero_reg_stored_byp: got %h expected 0", rd_a);
    end
    n_cmp++;
    if (rd_b !== 64'd0) begin
      n_err++; $display("FAIL zero_reg_stored_nobyp: got %h expected 0", rd_b);
    end
  endtask

  task automatic test_bypass();
    @(negedge clk); we0 = 1'b1; wr0 = 5'd7; wd0 = 32'h11;
    @(negedge clk); wd0 = 32'h22; ra = {5'd7, 5'd7}; #1;
    n_cmp++;
    if (rd_a !== {32'h22, 32'h22}) begin
      n_err++; $display("FAIL bypass_pre_byp: got %h expected 22 on both ports", rd_a);
    end
    n_cmp++;
    if (rd_b !== {32'h11, 32'h11}) begin
      n_err++; $display("FAIL bypass_pre_nobyp: got %h expected 11 on both ports", rd_b);
    end
    @(posedge clk); #1; idle(); #1;
    n_cmp++;
    if (rd_a !== {32'h22, 32'h22}) begin
      n_err++; $display("FAIL bypass_post_byp: got %h expected 22 on both ports", rd_a);
    end
    n_cmp++;
    if (rd_b !== {32'h22, 32'h22}) begin
      n_err++; $display("FAIL bypass_post_nobyp: got %h expected 22 on both ports", rd_b);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    we0 = 1'b1; wr0 = 5'd9; wd0 = 32'h55;
    we1 = 1'b1; wr1 = 5'd9; wd1 = 32'h66;
    ra = {5'd9, 5'd9}; #1;
    n_cmp++;
    if (rd_a !== {32'h66, 32'h66}) begin
      n_err++; $display("FAIL collide_pre_byp: got %h expected 66 on both ports", rd_a);
    end
    n_cmp++;
    if (rd_b !== {32'hA000_0009, 32'hA000_0009}) begin
      n_err++; $display("FAIL collide_pre_nobyp: got %h expected a0000009 on both ports", rd_b);
    end
    @(negedge clk);
    wr0 = 5'd4; wd0 = 32'h44; wr1 = 5'd5; wd1 = 32'h45; #1;
    n_cmp++;
    if (rd_a !== {32'h66, 32'h66}) begin
      n_err++; $display("FAIL collide_post_byp: got %h expected 66 on both ports", rd_a);
    end
    n_cmp++;
    if (rd_b !== {32'h66, 32'h66}) begin
      n_err++; $display("FAIL collide_post_nobyp: got %h expected 66 on both ports", rd_b);
    end
    ra = {5'd5, 5'd4}; #1;
    n_cmp++;
    if (rd_a !== {32'h45, 32'h44}) begin
      n_err++; $display("FAIL distinct_pre_byp: got %h expected 45/44", rd_a);
    end
    n_cmp++;
    if (rd_b !== {32'hA000_0005, 32'hA000_0004}) begin
      n_err++; $display("FAIL distinct_pre_nobyp: got %h expected a0000005/a0000004", rd_b);
    end
    @(negedge clk); idle(); #1;
    n_cmp++;
    if (rd_a !== {32'h45, 32'h44}) begin
      n_err++; $display("FAIL distinct_post_byp: got %h expected 45/44", rd_a);
    end
    n_cmp++;
    if (rd_b !== {32'h45, 32'h44}) begin
      n_err++; $display("FAIL distinct_post_nobyp: got %h expected 45/44", rd_b);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); we0 = 1'b1; wr0 = 5'd3; wd0 = 32'h33;
    @(negedge clk); reset = 1'b1; wd0 = 32'hFF; ra = {5'd3, 5'd3}; #1;
    n_cmp++;
    if (rd_a !== {32'h33, 32'h33}) begin
      n_err++; $display("FAIL reset_mid_pre_byp: got %h expected 33 on both ports", rd_a);
    end
    n_cmp++;
    if (rd_b !== {32'h33, 32'h33}) begin
      n_err++; $display("FAIL reset_mid_pre_nobyp: got %h expected 33 on both ports", rd_b);
    end
    @(posedge clk); #1; reset = 1'b0; idle(); #1;
    n_cmp++;
    if (rd_a !== 64'd0) begin
      n_err++; $display("FAIL reset_mid_post_byp: got %h expected 0", rd_a);
    end
    n_cmp++;
    if (rd_b !== 64'd0) begin
      n_err++; $display("FAIL reset_mid_post_nobyp: got %h expected 0", rd_b);
    end
    ra = {5'd9, 5'd31}; #1;
    n_cmp++;
    if (rd_a !== 64'd0) begin
      n_err++; $display("FAIL reset_mid_clear_9_31: got %h expected 0", rd_a);
    end
  endtask

  task automatic test_small_params();
    @(negedge clk); s_we0 = 1'b1; s_wr0 = 5'd0; s_wd0 = 16'hBEEF;
    s_ra = {5'd0, 5'd0, 5'd0, 5'd0}; #1;
    n_cmp++;
    if (s_rd !== 64'hBEEF_BEEF_BEEF_BEEF) begin
      n_err++; $display("FAIL small_reg0_pre: got %h expected beef on all ports", s_rd);
    end
    @(negedge clk); s_wr0 = 5'd12; s_wd0 = 16'h1234;
    s_ra = {5'd4, 5'd12, 5'd12, 5'd0}; #1;
    n_cmp++;
    if (s_rd !== 64'h0000_0000_0000_BEEF) begin
      n_err++; $display("FAIL small_oob_pre: got %h expected 000000000000beef", s_rd);
    end
    @(negedge clk); idle(); #1;
    n_cmp++;
    if (s_rd !== 64'h0000_0000_0000_BEEF) begin
      n_err++; $display("FAIL small_oob_post: got %h expected 000000000000beef", s_rd);
    end
    s_ra = {5'd0, 5'd0, 5'd0, 5'd0}; #1;
    n_cmp++;
    if (s_rd !== 64'hBEEF_BEEF_BEEF_BEEF) begin
      n_err++; $display("FAIL small_reg0_post: got %h expected beef on all ports", s_rd);
    end
    @(negedge clk);
    s_we0 = 1'b1; s_wr0 = 5'd2; s_wd0 = 16'hAAAA;
    s_we1 = 1'b1; s_wr1 = 5'd2; s_wd1 = 16'hBBBB;
    @(negedge clk); idle(); s_ra = {5'd2, 5'd2, 5'd7, 5'd2}; #1;
    n_cmp++;
    if (s_rd !== 64'hBBBB_BBBB_0000_BBBB) begin
      n_err++; $display("FAIL small_collide: got %h expected bbbbbbbb0000bbbb", s_rd);
    end
  endtask

  initial begin
    reset = 1'b0; ra = '0; s_ra = '0;
    wr0 = '0; wd0 = '0; wr1 = '0; wd1 = '0;
    s_wr0 = '0; s_wd0 = '0; s_wr1 = '0; s_wd1 = '0;
    idle();
    test_reset();
    test_fill();
    test_bypass();
    test_back_to_back();
    test_reset_mid();
    test_small_params();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
